// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with a 2-entry result buffer and one cycle of latency.
// Optional macro LOGIC_ACC_EN adds a chaining accumulator that can stand in for operand A.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_any,
  output logic             y_par
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa_p0;
  logic [WIDTH-1:0] res_p0;
  logic [WIDTH-1:0] head_p1;
  logic [WIDTH-1:0] tail_p1;
  logic             push;
  logic             pop;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] p,
                                                input logic [WIDTH-1:0] q);
    case (sel)
      3'd0:    logic_op = p & q;
      3'd1:    logic_op = p | q;
      3'd2:    logic_op = p ^ q;
      3'd3:    logic_op = ~(p & q);
      3'd4:    logic_op = ~(p | q);
      3'd5:    logic_op = ~(p ^ q);
      3'd6:    logic_op = p;
      default: logic_op = ~p;
    endcase
  endfunction

  // Handshake flags depend on registered state only, so out_ready never reaches in_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef LOGIC_ACC_EN
  logic [WIDTH-1:0] acc_p1;

  assign opa_p0 = in_first ? a : acc_p1;

  always_ff @(posedge clk) begin
    if (rst)
      acc_p1 <= '0;
    else if (push)
      acc_p1 <= res_p0;
  end
`else
  logic unused_in_first;

  assign unused_in_first = in_first;
  assign opa_p0          = a;
`endif

  // Stage p0: combinational operation on the accepted beat
  assign res_p0 = logic_op(op, opa_p0, b);

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (!push && pop) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  // Stage p1: head always holds the oldest result; tail holds the second one when FULL
  always_ff @(posedge clk) begin
    if (rst) begin
      head_p1 <= '0;
      tail_p1 <= '0;
    end else begin
      case (state)
        EMPTY: if (push) head_p1 <= res_p0;
        ONE: begin
          if (push && pop)
            head_p1 <= res_p0;
          else if (push)
            tail_p1 <= res_p0;
        end
        FULL:  if (pop) head_p1 <= tail_p1;
        default: ;
      endcase
    end
  end

  assign y     = head_p1;
  assign y_any = |head_p1;
  assign y_par = ^head_p1;

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result bit width; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  producer has a beat on a/b/op/in_first.
REQ-005 in_ready  output  1  block can accept a beat this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 op  input  3  operation select, see REQ-013.
REQ-009 in_first  input  1  accumulation chain start; used only with LOGIC_ACC_EN.
REQ-010 out_valid  output  1  y/y_any/y_par hold a valid result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 y  output  WIDTH  result; y_any  output  1  OR-reduction of y; y_par  output  1  XOR-reduction of y.

Function
REQ-013 op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 pass A, 7 NOT A; bitwise over WIDTH bits, no carries.
REQ-014 Beat accepted on an edge where in_valid & in_ready; result is computed from that cycle's inputs and stored in a 2-entry result buffer.
REQ-015 Result popped on an edge where out_valid & out_ready.
REQ-016 Buffer states: EMPTY (count 0), ONE (count 1), FULL (count 2); push only -> count+1, pop only -> count-1, push+pop -> count unchanged.
REQ-017 in_ready = (count != 2), from registered state only; no combinational path from out_ready to in_ready.
REQ-018 out_valid = (count != 0); y, y_any and y_par always show the oldest stored entry.
REQ-019 Latency: a beat accepted at edge k is visible on y with out_valid high immediately after edge k (one cycle); results are delivered in acceptance order.
REQ-020 FULL with out_ready high: pop only, and in_ready rises after that edge.
REQ-021 ONE with push and pop on the same edge: the new result becomes the head and state stays ONE.
REQ-022 When out_valid is high and out_ready is low, y/y_any/y_par stay stable until popped.
REQ-023 in_valid low, or in_ready low: no state change from the input side; input values are don't-care.

Reset
REQ-024 On an edge with rst high: count=0, in_ready=1, out_valid=0, y=0, y_any=0, y_par=0, accumulator=0.
REQ-025 Reset mid-operation discards all buffered results regardless of in_valid/out_ready that cycle; no beat is accepted or popped on a reset edge.
REQ-026 First accept is possible on the first edge after rst deasserts.

Configuration
REQ-027 Macro LOGIC_ACC_EN defined: a WIDTH-bit accumulator is loaded with every accepted result.
REQ-028 With LOGIC_ACC_EN, in_first=1 uses port a as operand A, and in_first=0 uses the accumulator as operand A; b is always port b.
REQ-029 LOGIC_ACC_EN undefined: no accumulator; in_first is present but ignored; operand A is always port a.

Verification
REQ-030 WIDTH=8, reset, then a=0xF0, b=0x3C, op=2, out_ready=1 -> next cycle y=0xCC, y_any=1, y_par=0, out_valid=1 for one cycle.
REQ-031 out_ready=0, three back-to-back beats with op=1 -> first two accepted, in_ready=0 on the third cycle; raise out_ready -> results pop in order and in_ready returns after the first pop.
REQ-032 All ops, a=0xA5, b=0x0F -> y = 05, AF, AA, FA, 50, 55, A5, 5A for ops 0..7.
REQ-033 LOGIC_ACC_EN, op=2: (a=0x01, b=0x02, in_first=1), then b=0x04 and b=0x08 with in_first=0 -> y = 0x03, 0x07, 0x0F; without the macro and a=0 -> y = 0x02, 0x04, 0x08.
REQ-034 FULL buffer, assert rst for one cycle with in_valid=1 and out_ready=1 -> after the edge out_valid=0, y=0, in_ready=1, and no result from before reset ever appears.
REQ-035 Continuous in_valid and out_ready for 100 random beats -> one result per cycle, no drops or duplicates, and y matches the reference model every cycle.
